// File: rtl/keccak_pkg.sv
// Shared definitions for the keccak core and its requester arbiter:
// mode encodings, sponge constants and the output-beat count helper.
package keccak_pkg;

    localparam int MODE_W = 2;
    localparam int BEAT_W = 8;

    localparam logic [MODE_W-1:0] MODE_SHAKE128 = 2'd0;
    localparam logic [MODE_W-1:0] MODE_SHAKE256 = 2'd1;
    localparam logic [MODE_W-1:0] MODE_SHA3_256 = 2'd2;
    localparam logic [MODE_W-1:0] MODE_SHA3_512 = 2'd3;

    // Rates in bytes and domain-separation suffixes
    localparam int RATE_SHAKE128 = 168;
    localparam int RATE_SHAKE256 = 136;
    localparam int RATE_SHA3_256 = 136;
    localparam int RATE_SHA3_512 = 72;

    localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;
    localparam logic [7:0] SUFFIX_SHA3  = 8'h06;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } arb_state_e;

    // Number of 64-bit output words a job produces; SHAKE rounds up and never yields zero.
    function automatic logic [BEAT_W-1:0] target_beats(input logic [MODE_W-1:0] mode,
                                                       input logic [9:0]        obyte_len);
        logic [10:0]       sum;
        logic [BEAT_W-1:0] t;
        sum = {1'b0, obyte_len} + 11'd7;
        t   = sum[10:3];
        case (mode)
            MODE_SHA3_256: t = 8'd4;
            MODE_SHA3_512: t = 8'd8;
            default: begin
                if (t == '0) t = 8'd1;
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/keccak_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module keccak_rr_pick #(
    parameter int N_REQ  = 4,
    parameter int BW_IDX = 2
) (
    input  logic [N_REQ-1:0]  req_i,
    input  logic [BW_IDX-1:0] ptr_i,
    output logic              found_o,
    output logic [BW_IDX-1:0] idx_o
);

    logic [BW_IDX:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_i} + (BW_IDX+1)'(i);
            if (cand >= (BW_IDX+1)'(N_REQ)) cand = cand - (BW_IDX+1)'(N_REQ);
            if (!found_o && req_i[cand[BW_IDX-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[BW_IDX-1:0];
            end
        end
    end

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one keccak core between N_REQ requesters; the round-robin winner keeps
// the core until the expected number of output words has been squeezed.
//
// state  | meaning
// S_IDLE | no job; pick a winner and latch its mode/lengths
// S_RUN  | winner granted; streams muxed to/from the core, output beats counted
// S_DONE | one-cycle done pulse to the winner, round-robin pointer advanced
module keccak_arbiter
    import keccak_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int BW_IDX  = 2,
    parameter int BW_CTRL = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*BW_CTRL-1:0] i_mode,
    input  logic [N_REQ*11-1:0]      i_ibyte_len,
    input  logic [N_REQ*10-1:0]      i_obyte_len,
    input  logic [N_REQ*64-1:0]      i_bytes,
    input  logic [N_REQ-1:0]         i_bytes_valid,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [63:0]              o_bytes,
    output logic [N_REQ-1:0]         o_bytes_valid,
    output logic [N_REQ-1:0]         o_done,
    output logic                     o_busy,
    output logic [BW_CTRL-1:0]       o_core_mode,
    output logic [10:0]              o_core_ibyte_len,
    output logic [9:0]               o_core_obyte_len,
    output logic [63:0]              o_core_bytes,
    output logic                     o_core_bytes_valid,
    input  logic [63:0]              i_core_bytes,
    input  logic                     i_core_bytes_valid
);

    arb_state_e          state_q, state_d;
    logic [BW_IDX-1:0]   ptr_q, ptr_d;
    logic [BW_IDX-1:0]   idx_q, idx_d;
    logic [BW_CTRL-1:0]  mode_q, mode_d;
    logic [10:0]         ilen_q, ilen_d;
    logic [9:0]          olen_q, olen_d;
    logic [BEAT_W-1:0]   target_q, target_d;
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;

    logic                found;
    logic [BW_IDX-1:0]   win;
    logic [BW_CTRL-1:0]  win_mode;
    logic [9:0]          win_olen;

    keccak_rr_pick #(
        .N_REQ  (N_REQ),
        .BW_IDX (BW_IDX)
    ) u_pick (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (win)
    );

    assign win_mode = i_mode[win*BW_CTRL +: BW_CTRL];
    assign win_olen = i_obyte_len[win*10 +: 10];

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            mode_q   <= '0;
            ilen_q   <= '0;
            olen_q   <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            ilen_q   <= ilen_d;
            olen_q   <= olen_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        ptr_d              = ptr_q;
        idx_d              = idx_q;
        mode_d             = mode_q;
        ilen_d             = ilen_q;
        olen_d             = olen_q;
        target_d           = target_q;
        cnt_d              = cnt_q;
        gnt_d              = gnt_q;
        o_done             = '0;
        o_bytes_valid      = '0;
        o_core_bytes       = '0;
        o_core_bytes_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    idx_d    = win;
                    mode_d   = win_mode;
                    ilen_d   = i_ibyte_len[win*11 +: 11];
                    olen_d   = win_olen;
                    target_d = target_beats(win_mode, win_olen);
                    cnt_d    = '0;
                    gnt_d    = N_REQ'(1) << win;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                o_core_bytes         = i_bytes[idx_q*64 +: 64];
                o_core_bytes_valid   = i_bytes_valid[idx_q];
                o_bytes_valid[idx_q] = i_core_bytes_valid;
                if (i_core_bytes_valid) begin
                    cnt_d = cnt_q + BEAT_W'(1);
                    if (cnt_d == target_q) begin
                        gnt_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                o_done[idx_q] = 1'b1;
                ptr_d   = (idx_q == BW_IDX'(N_REQ-1)) ? '0 : idx_q + BW_IDX'(1);
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_gnt            = gnt_q;
    assign o_bytes          = i_core_bytes;
    assign o_busy           = (state_q != S_IDLE);
    assign o_core_mode      = mode_q;
    assign o_core_ibyte_len = ilen_q;
    assign o_core_obyte_len = olen_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter: grant order, beat counting per mode,
// stream isolation, mid-job request drop and mid-job reset.
module tb_keccak_arbiter;
    import keccak_pkg::*;

    logic         clk;
    logic         rstn;
    logic [3:0]   req;
    logic [7:0]   mode_p;
    logic [43:0]  ilen_p;
    logic [39:0]  olen_p;
    logic [255:0] bytes_p;
    logic [3:0]   bv;
    logic [63:0]  cb;
    logic         cv;

    logic [3:0]   o_gnt;
    logic [63:0]  o_bytes;
    logic [3:0]   o_bytes_valid;
    logic [3:0]   o_done;
    logic         o_busy;
    logic [1:0]   o_core_mode;
    logic [10:0]  o_core_ibyte_len;
    logic [9:0]   o_core_obyte_len;
    logic [63:0]  o_core_bytes;
    logic         o_core_bytes_valid;

    logic [1:0]   t_mode  [4];
    logic [10:0]  t_ilen  [4];
    logic [9:0]   t_olen  [4];
    logic [63:0]  t_bytes [4];

    int n_checks = 0;
    int n_fail   = 0;

    keccak_arbiter #(.N_REQ(4), .BW_IDX(2), .BW_CTRL(2)) dut (
        .i_clk              (clk),
        .i_rstn             (rstn),
        .i_req              (req),
        .i_mode             (mode_p),
        .i_ibyte_len        (ilen_p),
        .i_obyte_len        (olen_p),
        .i_bytes            (bytes_p),
        .i_bytes_valid      (bv),
        .o_gnt              (o_gnt),
        .o_bytes            (o_bytes),
        .o_bytes_valid      (o_bytes_valid),
        .o_done             (o_done),
        .o_busy             (o_busy),
        .o_core_mode        (o_core_mode),
        .o_core_ibyte_len   (o_core_ibyte_len),
        .o_core_obyte_len   (o_core_obyte_len),
        .o_core_bytes       (o_core_bytes),
        .o_core_bytes_valid (o_core_bytes_valid),
        .i_core_bytes       (cb),
        .i_core_bytes_valid (cv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mode_p  = '0;
        ilen_p  = '0;
        olen_p  = '0;
        bytes_p = '0;
        for (int k = 0; k < 4; k++) begin
            mode_p[k*2 +: 2]   = t_mode[k];
            ilen_p[k*11 +: 11] = t_ilen[k];
            olen_p[k*10 +: 10] = t_olen[k];
            bytes_p[k*64 +: 64] = t_bytes[k];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Entered right after the grant edge; leaves the DUT back in S_IDLE.
    task automatic do_job(input int k, input int nb, input bit drop);
        logic [3:0]  oh;
        logic [10:0] inv;
        oh = 4'b1 << k;
        check_eq("gnt", {60'd0, o_gnt}, {60'd0, oh});
        check_eq("busy_run", {63'd0, o_busy}, 64'd1);
        check_eq("core_mode", {62'd0, o_core_mode}, {62'd0, t_mode[k]});
        check_eq("core_ilen", {53'd0, o_core_ibyte_len}, {53'd0, t_ilen[k]});
        check_eq("core_olen", {54'd0, o_core_obyte_len}, {54'd0, t_olen[k]});
        inv = ~t_ilen[k];
        t_ilen[k] = inv;
        #1 check_eq("ilen_hold", {53'd0, o_core_ibyte_len}, {53'd0, ~inv});
        t_ilen[k] = ~inv;
        if (drop) req[k] = 1'b0;
        bv = ~oh;
        #1 check_eq("core_valid_other", {63'd0, o_core_bytes_valid}, 64'd0);
        bv = oh;
        #1 check_eq("core_valid_own", {63'd0, o_core_bytes_valid}, 64'd1);
        check_eq("core_bytes", o_core_bytes, t_bytes[k]);
        bv = 4'b0;
        for (int b = 0; b < nb; b++) begin
            cb = 64'hC0DE_0000_0000_0000 + 64'(b);
            cv = 1'b1;
            #1 check_eq("out_valid", {60'd0, o_bytes_valid}, {60'd0, oh});
            check_eq("out_bytes", o_bytes, 64'hC0DE_0000_0000_0000 + 64'(b));
            cyc();
            if (b < nb - 1) check_eq("done_early", {60'd0, o_done}, 64'd0);
        end
        cv = 1'b0;
        #1 check_eq("done", {60'd0, o_done}, {60'd0, oh});
        check_eq("gnt_done", {60'd0, o_gnt}, 64'd0);
        cyc();
        check_eq("done_clear", {60'd0, o_done}, 64'd0);
        check_eq("busy_idle", {63'd0, o_busy}, 64'd0);
    endtask

    initial begin
        rstn = 1'b0;
        req  = 4'b0;
        bv   = 4'b0;
        cv   = 1'b0;
        cb   = '0;
        for (int k = 0; k < 4; k++) begin
            t_bytes[k] = 64'hA5A5_0000_0000_0010 + 64'(k);
            t_mode[k]  = MODE_SHA3_256;
            t_ilen[k]  = 11'd0;
            t_olen[k]  = 10'd0;
        end
        t_ilen[1] = 11'd32;
        cyc();
        cyc();
        check_eq("rst_gnt", {60'd0, o_gnt}, 64'd0);
        check_eq("rst_busy", {63'd0, o_busy}, 64'd0);
        check_eq("rst_done", {60'd0, o_done}, 64'd0);
        check_eq("rst_core_mode", {62'd0, o_core_mode}, 64'd0);
        check_eq("rst_core_ilen", {53'd0, o_core_ibyte_len}, 64'd0);
        check_eq("rst_core_valid", {63'd0, o_core_bytes_valid}, 64'd0);

        // Single requester 1, SHA3-256, 32-byte input
        rstn = 1'b1;
        req  = 4'b0010;
        cyc();
        do_job(1, 4, 1'b0);
        req = 4'b0;
        cyc();
        check_eq("idle_no_gnt", {60'd0, o_gnt}, 64'd0);

        // All four requesting from reset, mixed modes
        rstn = 1'b0;
        t_mode[0] = MODE_SHAKE128; t_olen[0] = 10'd33;  t_ilen[0] = 11'd100;
        t_mode[1] = MODE_SHAKE256; t_olen[1] = 10'd0;   t_ilen[1] = 11'd201;
        t_mode[2] = MODE_SHA3_512; t_olen[2] = 10'd200; t_ilen[2] = 11'd302;
        t_mode[3] = MODE_SHA3_256; t_olen[3] = 10'd5;   t_ilen[3] = 11'd403;
        req = 4'b1111;
        cyc();
        cyc();
        rstn = 1'b1;
        cyc();
        do_job(0, 5, 1'b0);
        cyc();
        do_job(1, 1, 1'b0);
        cyc();
        do_job(2, 8, 1'b0);
        cyc();
        do_job(3, 4, 1'b1);
        cyc();
        do_job(0, 5, 1'b0);

        // Requester 1 next; reset it mid-job
        req = 4'b1111;
        t_olen[1] = 10'd100;
        cyc();
        check_eq("gnt_r1", {60'd0, o_gnt}, 64'h2);
        check_eq("olen_r1", {54'd0, o_core_obyte_len}, 64'd100);
        cv = 1'b1;
        cyc();
        cyc();
        check_eq("mid_no_done", {60'd0, o_done}, 64'd0);
        rstn = 1'b0;
        cyc();
        check_eq("mrst_gnt", {60'd0, o_gnt}, 64'd0);
        check_eq("mrst_done", {60'd0, o_done}, 64'd0);
        check_eq("mrst_busy", {63'd0, o_busy}, 64'd0);
        check_eq("mrst_valid", {60'd0, o_bytes_valid}, 64'd0);
        check_eq("mrst_olen", {54'd0, o_core_obyte_len}, 64'd0);
        check_eq("mrst_mode", {62'd0, o_core_mode}, 64'd0);
        rstn = 1'b1;
        #1 check_eq("idle_drop_valid", {60'd0, o_bytes_valid}, 64'd0);
        cv = 1'b0;
        cyc();
        do_job(0, 5, 1'b0);
        req = 4'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_arbiter.md
Name: keccak_arbiter

Overview:
- Shares one keccak core (SHAKE128/SHAKE256/SHA3-256/SHA3-512, 64-bit byte stream) between N_REQ Kyber requesters, e.g. matrix-gen SHAKE128, PRF SHAKE256, H/G hashes.
- Round-robin arbitration; the winner is locked until its whole job finishes.
- Latches the winner's mode and lengths, muxes its input stream to the core and routes core output words back to it.
- Counts squeezed output words to detect job completion, because the core has no done signal.

Parameters:
- N_REQ, 4, number of requesters.
- BW_IDX, 2, requester index width, clog2(N_REQ).
- BW_CTRL, 2, mode width.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  synchronous active-low reset.
- i_req  in  N_REQ  job request, one bit per requester; held until o_done.
- i_mode  in  N_REQ*BW_CTRL  per-requester mode, packed with requester k at [k*BW_CTRL +: BW_CTRL].
- i_ibyte_len  in  N_REQ*11  per-requester input length in bytes.
- i_obyte_len  in  N_REQ*10  per-requester output length in bytes; used for SHAKE modes only.
- i_bytes  in  N_REQ*64  per-requester input words.
- i_bytes_valid  in  N_REQ  per-requester input word valid.
- o_gnt  out  N_REQ  one-hot grant, registered.
- o_bytes  out  64  core output word, broadcast to all requesters.
- o_bytes_valid  out  N_REQ  output word valid, asserted only for the granted requester.
- o_done  out  N_REQ  one-cycle job-complete pulse.
- o_busy  out  1  high whenever the state is not S_IDLE.
- o_core_mode  out  BW_CTRL  latched mode driven to the core.
- o_core_ibyte_len  out  11  latched input length driven to the core.
- o_core_obyte_len  out  10  latched output length driven to the core.
- o_core_bytes  out  64  input word driven to the core.
- o_core_bytes_valid  out  1  input word valid driven to the core.
- i_core_bytes  in  64  output word from the core.
- i_core_bytes_valid  in  1  output word valid from the core.

Behaviour:
- Reset (i_rstn low at a rising edge):
  - state = S_IDLE, ptr = 0, idx = 0, beat counter = 0.
  - Latched mode and lengths = 0.
  - o_gnt, o_done, o_bytes_valid, o_core_bytes_valid, o_busy = 0.
  - Mid-job reset aborts the job with no o_done. The core shares i_rstn.
- Modes: SHAKE128 = 0, SHAKE256 = 1, SHA3_256 = 2, SHA3_512 = 3.
- Target beats:
  - SHAKE modes: (obyte_len + 7) >> 3, computed at 11-bit width; a value of 0 is forced to 1.
  - SHA3_256: 4. SHA3_512: 8.
- FSM with three states:
  - S_IDLE: if any i_req is high, winner = first requester at or after ptr in ascending order, wrapping modulo N_REQ. At the same edge: latch idx, mode, ibyte_len, obyte_len; latch the target count; clear the beat counter; go to S_RUN. Otherwise stay.
  - S_RUN:
    - o_gnt[idx] = 1.
    - o_core_bytes = i_bytes[idx] and o_core_bytes_valid = i_bytes_valid[idx], combinational.
    - o_bytes = i_core_bytes. o_bytes_valid[idx] = i_core_bytes_valid, combinational with zero latency.
    - Each core-valid beat increments the counter. The beat that makes count == target moves to S_DONE.
  - S_DONE: o_done[idx] = 1 for one cycle; o_gnt = 0; ptr <= idx + 1 modulo N_REQ; go to S_IDLE.
- Latency:
  - i_req high in S_IDLE at edge t gives o_gnt and stable core config from t+1.
  - The requester may stream input whenever its o_gnt bit is high.
  - o_done is high the cycle after the final output beat.
  - Minimum spacing between two grants is 2 cycles (S_DONE, then S_IDLE).
- Core config outputs stay constant from entering S_RUN until S_IDLE.
- i_bytes_valid from non-granted requesters is ignored.
- i_core_bytes_valid outside S_RUN is dropped: no o_bytes_valid and no count.
- Boundary cases:
  - i_req dropped mid-job: ignored; the job runs to completion and o_done still pulses.
  - i_req still high during S_DONE: re-arbitrated fairly in S_IDLE, starting from the updated ptr.
  - Simultaneous requests: resolved purely by ptr.
  - Requester inputs other than i_req are sampled only at the S_IDLE→S_RUN edge.

Decomposition:
- Shared package keccak_pkg: mode localparams; rate and suffix constants; target-beat function shared with the keccak core.
- One natural sub-module, keccak_rr_pick: combinational round-robin picker. Inputs are the request vector and ptr; outputs are a found flag and the winner index.

Test Plan:
- Only i_req[1], SHA3_256, ibyte_len = 32:
  - o_gnt = 4'b0010 one cycle later.
  - Core sees only requester 1's words.
  - Exactly 4 o_bytes_valid[1] beats, then an o_done[1] pulse on the next cycle.
  - o_busy is low two cycles after the last beat.
- i_req = 4'b1111 held from reset: grants in order 0,1,2,3,0, each after the previous requester's o_done.
- SHAKE128 with obyte_len = 33: done after 5 beats. With obyte_len = 0: done after 1 beat. SHA3_512: done after 8 beats.
- Requester 2 granted while requester 0 toggles i_bytes_valid: o_core_bytes_valid follows only requester 2; requester 0 never sees o_bytes_valid.
- i_req[3] dropped after the grant: job still completes with o_done[3].
- i_rstn low for one cycle mid-job: all outputs 0 at the next edge, no o_done; re-arbitration starts from ptr = 0.
- i_core_bytes_valid pulsed in S_IDLE: no o_bytes_valid. Next job's beat count is unaffected.
